// File: rtl/scan_out_pkg.sv
// scan_out_pkg -- shared definitions for the scan-out stage.
//   `ASSERT / `DEASSERT : read-strobe levels (rd_en is active-low), guarded
//   scan_state_e        : raster FSM state encoding
//   RD_ASSERT/RD_DEASSERT : the same levels as package constants for RTL use
//   bar_rgb()           : colour-bar index -> {R,G,B} on/off bits, used only
//                         when SCAN_TEST_PATTERN_EN is defined
`ifndef ASSERT
`define ASSERT 1'b0
`endif
`ifndef DEASSERT
`define DEASSERT 1'b1
`endif

package scan_out_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_LIVE     = 2'd2,
        ST_BLANK    = 2'd3
    } scan_state_e;

    localparam logic RD_ASSERT   = `ASSERT;
    localparam logic RD_DEASSERT = `DEASSERT;

    // Bars left to right: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic logic [2:0] bar_rgb(input logic [2:0] bar);
        logic [2:0] rgb;
        case (bar)
            3'd0:    rgb = 3'b111;
            3'd1:    rgb = 3'b110;
            3'd2:    rgb = 3'b011;
            3'd3:    rgb = 3'b010;
            3'd4:    rgb = 3'b101;
            3'd5:    rgb = 3'b100;
            3'd6:    rgb = 3'b001;
            default: rgb = 3'b000;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/scan_out_timing_cnt.sv
// scan_out_timing_cnt -- horizontal/vertical raster counters and region decode.
// Ports:
//   clk_i, reset_ni : pixel clock, async active-low reset
//   run_i           : 1 = count, 0 = hold both counters at 0
//   active_o        : h < H_ACTIVE and v < V_ACTIVE
//   hsync_o/vsync_o : raw (undelayed) sync regions, active-high
//   sof_o           : h == 0 and v == 0
//   h_o             : current h count (only with SCAN_TEST_PATTERN_EN)
module scan_out_timing_cnt #(
    parameter int CNT_W    = 12,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             run_i,
    output logic             active_o,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             sof_o
`ifdef SCAN_TEST_PATTERN_EN
   ,output logic [CNT_W-1:0] h_o
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (!run_i) begin
            h_d = '0;
            v_d = '0;
        end else if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
        end else begin
            h_d = h_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign active_o = (h_q < H_ACT) && (v_q < V_ACT);
    assign hsync_o  = (h_q >= HS_BEG) && (h_q < HS_END);
    assign vsync_o  = (v_q >= VS_BEG) && (v_q < VS_END);
    assign sof_o    = (h_q == '0) && (v_q == '0);

`ifdef SCAN_TEST_PATTERN_EN
    assign h_o = h_q;
`endif

endmodule

// File: rtl/scan_out.sv
// scan_out -- display scan-out stage downstream of the frame buffer.
// Generates raster timing, issues one active-low read per active pixel in
// live frames, realigns returned data with the timing, and blanks to black in
// frames where the buffer was not ready at frame start.
// Ports:
//   clk_i, reset_ni : pixel clock (frame buffer rd_clk), async active-low reset
//   enable_i        : 1 = run raster, 0 = return to idle
//   fb_rdy_i        : frame buffer holds a readable frame (sampled at SOF only)
//   test_pat_i      : colour-bar override (only with SCAN_TEST_PATTERN_EN)
//   rd_data_i       : pixel data, valid RD_LAT clocks after rd_en_o
//   rd_en_o         : read request, active-low
//   hsync_o/vsync_o : syncs, active level SYNC_POL
//   de_o, pix_o     : data enable and pixel, aligned; pix_o is 0 when de_o is 0
//   frame_start_o   : one-clock pulse at h=0,v=0, on the rd_en_o timebase
// Optional build macro: SCAN_TEST_PATTERN_EN adds test_pat_i and bar generator.
//
// state       | meaning
// ------------+----------------------------------------------------------
// ST_IDLE     | counters held at 0, outputs at reset values
// ST_WAIT_SOF | counters running, first cycle is the frame decision
// ST_LIVE     | frame is read from the buffer
// ST_BLANK    | full timing, no reads, pixels black
module scan_out
    import scan_out_pkg::*;
#(
    parameter int   DATA_WIDTH = 24,
    parameter int   H_ACTIVE   = 640,
    parameter int   H_FP       = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BP       = 48,
    parameter int   V_ACTIVE   = 480,
    parameter int   V_FP       = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BP       = 33,
    parameter logic SYNC_POL   = 1'b0,
    parameter int   RD_LAT     = 1,
    parameter int   CNT_W      = 12
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  enable_i,
    input  logic                  fb_rdy_i,
`ifdef SCAN_TEST_PATTERN_EN
    input  logic                  test_pat_i,
`endif
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    output logic                  rd_en_o,
    output logic                  hsync_o,
    output logic                  vsync_o,
    output logic                  de_o,
    output logic [DATA_WIDTH-1:0] pix_o,
    output logic                  frame_start_o
);

    scan_state_e state_q, state_d;

    logic cnt_run, cnt_active, cnt_hs, cnt_vs, cnt_sof;
    logic go_live, rd_ok, live_now, raster_on;

    // Stages 0..RD_LAT of the timing pipe; the last stage drives the outputs.
    logic [RD_LAT:0]   de_pipe_q, hs_pipe_q, vs_pipe_q;
    // Live flag only needs to reach the stage that loads the pixel register.
    logic [RD_LAT-1:0] live_pipe_q;
    logic [DATA_WIDTH-1:0] pix_q, pix_d;

`ifdef SCAN_TEST_PATTERN_EN
    localparam int CH_W = DATA_WIDTH / 3;

    logic [CNT_W-1:0]  cnt_h;
    logic [RD_LAT-1:0] tp_pipe_q;
    logic [CNT_W-1:0]  h_pipe_q [RD_LAT];

    function automatic logic [DATA_WIDTH-1:0] bar_pixel(input logic [CNT_W-1:0] h);
        logic [2:0] rgb;
        int         bar;
        bar = (int'(h) * 8) / H_ACTIVE;
        rgb = bar_rgb(3'(bar));
        return DATA_WIDTH'({{CH_W{rgb[2]}}, {CH_W{rgb[1]}}, {CH_W{rgb[0]}}});
    endfunction

    // The pattern counts as a ready buffer so the frame runs with LIVE timing,
    // but no reads are issued while it is shown.
    assign go_live = fb_rdy_i | test_pat_i;
    assign rd_ok   = ~test_pat_i;
`else
    assign go_live = fb_rdy_i;
    assign rd_ok   = 1'b1;
`endif

    scan_out_timing_cnt #(
        .CNT_W    (CNT_W),
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .run_i    (cnt_run),
        .active_o (cnt_active),
        .hsync_o  (cnt_hs),
        .vsync_o  (cnt_vs),
        .sof_o    (cnt_sof)
`ifdef SCAN_TEST_PATTERN_EN
       ,.h_o      (cnt_h)
`endif
    );

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // At h=0,v=0 the decision already governs that cycle's read, so live_now
    // uses the decided frame type rather than waiting for state_q to update.
    always_comb begin
        state_d       = state_q;
        rd_en_o       = RD_DEASSERT;
        frame_start_o = 1'b0;
        live_now      = 1'b0;
        raster_on     = (state_q != ST_IDLE);

        unique case (state_q)
            ST_IDLE: begin
                if (enable_i) state_d = ST_WAIT_SOF;
            end
            ST_WAIT_SOF, ST_LIVE, ST_BLANK: begin
                if (cnt_sof) begin
                    state_d       = go_live ? ST_LIVE : ST_BLANK;
                    frame_start_o = 1'b1;
                    live_now      = go_live;
                end else begin
                    live_now      = (state_q == ST_LIVE);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (live_now && cnt_active && rd_ok) rd_en_o = RD_ASSERT;
        if (!enable_i) state_d = ST_IDLE;
    end

    assign cnt_run = raster_on && enable_i;

    // Dropping enable flushes the pipe so in-flight reads never reach de_o.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            de_pipe_q   <= '0;
            hs_pipe_q   <= '0;
            vs_pipe_q   <= '0;
            live_pipe_q <= '0;
`ifdef SCAN_TEST_PATTERN_EN
            tp_pipe_q   <= '0;
            for (int i = 0; i < RD_LAT; i++) h_pipe_q[i] <= '0;
`endif
        end else if (!enable_i) begin
            de_pipe_q   <= '0;
            hs_pipe_q   <= '0;
            vs_pipe_q   <= '0;
            live_pipe_q <= '0;
`ifdef SCAN_TEST_PATTERN_EN
            tp_pipe_q   <= '0;
            for (int i = 0; i < RD_LAT; i++) h_pipe_q[i] <= '0;
`endif
        end else begin
            de_pipe_q      <= {de_pipe_q[RD_LAT-1:0], raster_on & cnt_active};
            hs_pipe_q      <= {hs_pipe_q[RD_LAT-1:0], raster_on & cnt_hs};
            vs_pipe_q      <= {vs_pipe_q[RD_LAT-1:0], raster_on & cnt_vs};
            live_pipe_q[0] <= live_now;
            for (int i = 1; i < RD_LAT; i++) live_pipe_q[i] <= live_pipe_q[i-1];
`ifdef SCAN_TEST_PATTERN_EN
            tp_pipe_q[0]   <= test_pat_i;
            h_pipe_q[0]    <= cnt_h;
            for (int i = 1; i < RD_LAT; i++) begin
                tp_pipe_q[i] <= tp_pipe_q[i-1];
                h_pipe_q[i]  <= h_pipe_q[i-1];
            end
`endif
        end
    end

    // Stage RD_LAT-1 lines up with the cycle rd_data_i is valid for that pixel.
    always_comb begin
        pix_d = '0;
        if (enable_i && de_pipe_q[RD_LAT-1]) begin
`ifdef SCAN_TEST_PATTERN_EN
            if (tp_pipe_q[RD_LAT-1]) begin
                pix_d = bar_pixel(h_pipe_q[RD_LAT-1]);
            end else if (live_pipe_q[RD_LAT-1]) begin
                pix_d = rd_data_i;
            end
`else
            if (live_pipe_q[RD_LAT-1]) pix_d = rd_data_i;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            pix_q <= '0;
        end else begin
            pix_q <= pix_d;
        end
    end

    assign de_o    = de_pipe_q[RD_LAT];
    assign hsync_o = hs_pipe_q[RD_LAT] ? SYNC_POL : ~SYNC_POL;
    assign vsync_o = vs_pipe_q[RD_LAT] ? SYNC_POL : ~SYNC_POL;
    assign pix_o   = pix_q;

endmodule
